// File: rtl/gradient_stream.sv
// rtl/gradient_stream.sv - per-pixel dI/dx, dI/dy with forward/central differences and border policy
// Three-stage elastic pipeline: input register, edge flags + differences, select/output.
module gradient_stream #(
    parameter int DATA_BW   = 8,
    parameter int H_SIZE_BW = 10,
    parameter int V_SIZE_BW = 9
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_BW-1:0]   i_data_0,
    input  logic [DATA_BW-1:0]   i_data_um,
    input  logic [DATA_BW-1:0]   i_data_up,
    input  logic [DATA_BW-1:0]   i_data_vm,
    input  logic [DATA_BW-1:0]   i_data_vp,
    input  logic [H_SIZE_BW-1:0] i_u,
    input  logic [V_SIZE_BW-1:0] i_v,
    input  logic [H_SIZE_BW-1:0] r_hsize,
    input  logic [V_SIZE_BW-1:0] r_vsize,
    input  logic [1:0]           r_mode,
    input  logic                 r_border,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_BW:0]     o_dI_dx,
    output logic [DATA_BW:0]     o_dI_dy
);

    localparam int DW = DATA_BW + 1;

    logic s1_load, s2_load, s3_load;
    logic s1_valid, s2_valid;

    logic [DATA_BW-1:0]   s1_p0, s1_um, s1_up, s1_vm, s1_vp;
    logic [H_SIZE_BW-1:0] s1_u, s1_hsize;
    logic [V_SIZE_BW-1:0] s1_v, s1_vsize;
    logic [1:0]           s1_mode;
    logic                 s1_border;

    logic          s2_xl, s2_xr, s2_yl, s2_yr;
    logic [DW-1:0] s2_fx, s2_cx, s2_bx, s2_fy, s2_cy, s2_by;
    logic [1:0]    s2_mode;
    logic          s2_border;

    logic          c_xl, c_xr, c_yl, c_yr;
    logic [DW-1:0] c_fx, c_cx, c_bx, c_fy, c_cy, c_by;

    // Each stage may refill as soon as its successor moves, so bubbles collapse.
    assign s3_load = !o_valid || i_ready;
    assign s2_load = !s2_valid || s3_load;
    assign s1_load = !s1_valid || s2_load;
    assign o_ready = s1_load;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load) s1_valid <= i_valid;
            if (s2_load) s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (s1_load && i_valid) begin
            s1_p0     <= i_data_0;
            s1_um     <= i_data_um;
            s1_up     <= i_data_up;
            s1_vm     <= i_data_vm;
            s1_vp     <= i_data_vp;
            s1_u      <= i_u;
            s1_v      <= i_v;
            s1_hsize  <= r_hsize;
            s1_vsize  <= r_vsize;
            s1_mode   <= r_mode;
            s1_border <= r_border;
        end
    end

    // Right/bottom edge as u+1 >= size in a widened domain, so size 0 never wraps.
    always_comb begin
        c_xl = (s1_u == '0);
        c_yl = (s1_v == '0);
        c_xr = (({1'b0, s1_u} + (H_SIZE_BW+1)'(1)) >= {1'b0, s1_hsize});
        c_yr = (({1'b0, s1_v} + (V_SIZE_BW+1)'(1)) >= {1'b0, s1_vsize});
        c_fx = {1'b0, s1_up} - {1'b0, s1_p0};
        c_cx = {1'b0, s1_up} - {1'b0, s1_um};
        c_bx = {1'b0, s1_p0} - {1'b0, s1_um};
        c_fy = {1'b0, s1_vp} - {1'b0, s1_p0};
        c_cy = {1'b0, s1_vp} - {1'b0, s1_vm};
        c_by = {1'b0, s1_p0} - {1'b0, s1_vm};
    end

    always_ff @(posedge i_clk) begin
        if (s2_load && s1_valid) begin
            s2_xl     <= c_xl;
            s2_xr     <= c_xr;
            s2_yl     <= c_yl;
            s2_yr     <= c_yr;
            s2_fx     <= c_fx;
            s2_cx     <= c_cx;
            s2_bx     <= c_bx;
            s2_fy     <= c_fy;
            s2_cy     <= c_cy;
            s2_by     <= c_by;
            s2_mode   <= s1_mode;
            s2_border <= s1_border;
        end
    end

    function automatic logic [DW-1:0] pick(
        input logic          l,
        input logic          r,
        input logic [DW-1:0] fwd,
        input logic [DW-1:0] cen,
        input logic [DW-1:0] bwd,
        input logic [1:0]    mode,
        input logic          border
    );
        logic [DW-1:0] res;
        res = '0;
        if (!l && !r) begin
            case (mode)
                2'd1:    res = cen;
                2'd2:    res = {cen[DW-1], cen[DW-1:1]};
                default: res = fwd;
            endcase
        end else if (border && !(l && r)) begin
            res = l ? fwd : bwd;
        end
        return res;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_dI_dx <= '0;
            o_dI_dy <= '0;
        end else if (s3_load) begin
            o_valid <= s2_valid;
            if (s2_valid) begin
                o_dI_dx <= pick(s2_xl, s2_xr, s2_fx, s2_cx, s2_bx, s2_mode, s2_border);
                o_dI_dy <= pick(s2_yl, s2_yr, s2_fy, s2_cy, s2_by, s2_mode, s2_border);
            end
        end
    end

endmodule

// File: tb/tb_gradient_stream.sv
// tb/tb_gradient_stream.sv - scoreboard bench for gradient_stream
module tb_gradient_stream;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data_0, i_data_um, i_data_up, i_data_vm, i_data_vp;
    logic [9:0] i_u, r_hsize;
    logic [8:0] i_v, r_vsize;
    logic [1:0] r_mode;
    logic       r_border;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic [8:0] o_dI_dx, o_dI_dy;

    gradient_stream #(.DATA_BW(8), .H_SIZE_BW(10), .V_SIZE_BW(9)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_0(i_data_0), .i_data_um(i_data_um), .i_data_up(i_data_up),
        .i_data_vm(i_data_vm), .i_data_vp(i_data_vp), .i_u(i_u), .i_v(i_v),
        .r_hsize(r_hsize), .r_vsize(r_vsize), .r_mode(r_mode), .r_border(r_border),
        .o_valid(o_valid), .i_ready(i_ready), .o_dI_dx(o_dI_dx), .o_dI_dy(o_dI_dy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int dx;
        int dy;
        bit lat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    int   bp_base = 0;
    bit   prev_stall = 0;
    int   prev_dx, prev_dy;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int grad(int p0, int pm, int pp, int pos, int size, int mode, int border);
        bit l, r;
        int m;
        l = (pos == 0);
        r = (pos >= size - 1);
        m = (mode == 3) ? 0 : mode;
        if (!l && !r) begin
            if (m == 0) return pp - p0;
            if (m == 1) return pp - pm;
            return (pp - pm) >>> 1;
        end
        if (border == 0 || (l && r)) return 0;
        if (l) return pp - p0;
        return p0 - pm;
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ($urandom_range(0, 3) != 0);
            default: i_ready = !((cyc - bp_base) >= 3 && (cyc - bp_base) <= 7);
        endcase
    end

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_stall = 0;
        end else begin
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("dx", int'($signed(o_dI_dx)), e.dx);
                    check("dy", int'($signed(o_dI_dy)), e.dy);
                    if (e.lat) check("latency", cyc - e.cyc, 3);
                end
            end
            if (prev_stall) begin
                check("hold_valid", int'(o_valid), 1);
                check("hold_dx", int'($signed(o_dI_dx)), prev_dx);
                check("hold_dy", int'($signed(o_dI_dy)), prev_dy);
            end
            if (!o_ready) check("not_ready_inflight", sb.size(), 3);
            prev_stall = o_valid && !i_ready;
            prev_dx    = int'($signed(o_dI_dx));
            prev_dy    = int'($signed(o_dI_dy));
        end
    end

    task automatic send(int p0, int um, int up, int vm, int vp, int u, int v,
                        int hs, int vs, int mode, int border, bit lat);
        int  t = 0;
        bit  done = 0;
        i_valid   = 1'b1;
        i_data_0  = 8'(p0);
        i_data_um = 8'(um);
        i_data_up = 8'(up);
        i_data_vm = 8'(vm);
        i_data_vp = 8'(vp);
        i_u       = 10'(u);
        i_v       = 9'(v);
        r_hsize   = 10'(hs);
        r_vsize   = 9'(vs);
        r_mode    = 2'(mode);
        r_border  = 1'(border);
        while (!done) begin
            @(negedge i_clk);
            if (o_ready) begin
                sb.push_back('{grad(p0, um, up, u, hs, mode, border),
                               grad(p0, vm, vp, v, vs, mode, border), lat, cyc});
                done = 1;
            end else if (++t > 100) begin
                check("accept_timeout", 0, 1);
                done = 1;
            end
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic idle();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 300) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int hs, vs;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data_0 = '0; i_data_um = '0; i_data_up = '0; i_data_vm = '0; i_data_vp = '0;
        i_u = '0; i_v = '0; r_hsize = 10'd640; r_vsize = 9'd480; r_mode = '0; r_border = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_o_valid", int'(o_valid), 0);
        check("reset_dx", int'(o_dI_dx), 0);
        check("reset_dy", int'(o_dI_dy), 0);
        i_rst_n = 1'b1;
        check("ready_after_release", int'(o_ready), 1);
        @(posedge i_clk);
        #1;

        // Legacy forward mode, interior and both x borders
        send(100, 77, 130, 33, 90, 5, 7, 640, 480, 0, 0, 1);
        idle(); drain();
        send(100, 77, 130, 33, 90, 0, 7, 640, 480, 0, 0, 1);
        send(100, 77, 130, 33, 90, 639, 7, 640, 480, 0, 0, 1);
        idle(); drain();

        // Central and halved-central, including negative floor
        send(60, 51, 200, 20, 220, 5, 7, 640, 480, 1, 0, 1);
        send(60, 51, 200, 20, 220, 5, 7, 640, 480, 2, 0, 1);
        send(60, 200, 51, 221, 20, 5, 7, 640, 480, 2, 0, 1);
        send(60, 200, 51, 221, 20, 5, 7, 640, 480, 3, 0, 1);
        idle(); drain();

        // One-sided border differences
        send(10, 99, 40, 5, 15, 0, 0, 640, 480, 2, 1, 1);
        send(10, 250, 99, 200, 0, 639, 479, 640, 480, 2, 1, 1);
        send(10, 250, 40, 3, 4, 0, 0, 1, 1, 2, 1, 1);
        send(255, 0, 0, 255, 0, 5, 479, 640, 480, 0, 1, 1);
        idle(); drain();

        // Mode switch between consecutive beats
        send(100, 40, 180, 10, 250, 5, 7, 640, 480, 0, 0, 1);
        send(100, 40, 180, 10, 250, 5, 7, 640, 480, 1, 0, 1);
        idle(); drain();

        // Backpressure burst
        bp_base = cyc;
        ready_mode = 2;
        for (int i = 0; i < 6; i++)
            send(20 + i * 7, 3 * i, 200 - i * 11, 9 * i, 100 + i, 3 + i, 4 + i, 640, 480, i % 3, 0, 0);
        idle(); drain();
        ready_mode = 0;

        // Randomised stream with random backpressure and gaps
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            hs = ($urandom_range(0, 3) == 0) ? 640 : int'($urandom_range(1, 5));
            vs = ($urandom_range(0, 3) == 0) ? 480 : int'($urandom_range(1, 5));
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, hs + 1)), int'($urandom_range(0, vs + 1)), hs, vs,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge i_clk);
                #1;
            end
        end
        idle(); drain();
        ready_mode = 0;
        repeat (2) @(posedge i_clk);
        #1;

        // Asynchronous reset with three beats in flight
        send(100, 77, 130, 33, 90, 5, 7, 640, 480, 0, 0, 0);
        send(110, 77, 140, 33, 95, 6, 7, 640, 480, 1, 0, 0);
        send(120, 77, 150, 33, 99, 7, 7, 640, 480, 2, 0, 0);
        idle();
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_o_valid", int'(o_valid), 0);
        check("async_rst_dx", int'(o_dI_dx), 0);
        check("async_rst_dy", int'(o_dI_dy), 0);
        sb.delete();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        check("ready_after_rst", int'(o_ready), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            check("no_stale_valid", int'(o_valid), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
